lab2_truth_sweep: RTL and testbench
===================================

LAB2_TRUTH_SWEEP -- requirements
Module: lab2_truth_sweep

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving clock cycles each input code is held before sampling (legal range 1..255).
REQ-002 SHALL have parameter EXPECT, default 8'h00, giving the expected truth table: bit i = expected dut_out for code i.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a sweep; sampled every cycle.
REQ-006 SHALL have port dut_out  input  1  response of the 3-input combinational block under test.
REQ-007 SHALL have ports x1, x2, x3  output  1 each  stimulus to the block under test; code[2]=x1, code[1]=x2, code[0]=x3.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-010 SHALL have port pass  output  1  registered result of the last completed sweep.
REQ-011 SHALL have port truth_table  output  8  captured responses; bit i = dut_out sampled for code i.
REQ-012 SHALL have port fail_idx  output  3  lowest code where truth_table differs from EXPECT; 0 when pass=1.

Function
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE: x1..x3=0, busy=0; start=1 at an edge -> SETTLE next cycle, code=0, settle counter=0, truth_table cleared to 8'h00.
REQ-015 SETTLE: drive code on x1..x3, busy=1; increment counter each cycle; after SETTLE_CYCLES cycles in SETTLE -> SAMPLE.
REQ-016 SAMPLE: one cycle; truth_table[code] <= dut_out; code=7 -> DONE; else code+1, counter=0, -> SETTLE.
REQ-017 Each code SHALL be driven for exactly SETTLE_CYCLES+1 cycles (settle plus sample); x1..x3 SHALL never glitch within a code.
REQ-018 DONE: one cycle; done=1, busy=1, x1..x3=0; pass <= (truth_table==EXPECT); fail_idx <= lowest mismatching index, or 0 when none; -> IDLE.
REQ-019 Latency: start accepted at edge k -> done high in the cycle beginning at edge k+8*(SETTLE_CYCLES+1)+1 (41 cycles at default).
REQ-020 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing of requests.
REQ-021 start held high continuously SHALL produce back-to-back sweeps, each starting in the cycle after DONE returns to IDLE.
REQ-022 pass, fail_idx and truth_table SHALL hold their values from DONE until the next sweep begins; truth_table updates live during a sweep.
REQ-023 Code counter SHALL be 3 bits and SHALL not wrap during a sweep; settle counter 8 bits, cleared on each code change.

Reset
REQ-024 rst_n=0 at an edge SHALL force state IDLE, code=0, counter=0, x1..x3=0, busy=0, done=0, pass=0, truth_table=8'h00, fail_idx=0.
REQ-025 Reset mid-sweep SHALL abort immediately with no done pulse; reset SHALL take priority over start.

Verification
REQ-026 Reset asserted 2 cycles, then released -> all outputs at REQ-024 values; start=0 keeps IDLE indefinitely.
REQ-027 Defaults, dut_out tied 0, start pulse at edge k -> done at k+41, truth_table=8'h00, pass=1, fail_idx=0.
REQ-028 dut_out=x1&x2&x3, EXPECT=8'h00 -> truth_table=8'h80, pass=0, fail_idx=7.
REQ-029 dut_out=x3, EXPECT=8'h00 -> truth_table=8'hAA, pass=0, fail_idx=1; each code observed on x1..x3 for exactly 5 cycles.
REQ-030 Reset asserted while code=3 in SETTLE -> next cycle all outputs at reset values, no done pulse; a later start runs a full sweep from code 0.
REQ-031 start held high 100 cycles at defaults -> done pulses at 41 and 83 cycles after the first accepted start, busy low exactly one cycle between sweeps.

Source files
------------

// File: rtl/lab2_truth_sweep.sv
// Truth-table sweeper: drives all eight codes onto a 3-input block, samples its
// response after a settle time and compares the captured table to EXPECT.
module lab2_truth_sweep #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECT        = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] truth_table,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    // Lowest set bit of a mismatch vector; 0 when the vector is clear.
    function automatic logic [2:0] first_mismatch(input logic [7:0] diff);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t     state_r, state_s;
    logic [2:0] code_r, code_s;
    logic [7:0] cnt_r, cnt_s;
    logic [7:0] table_r, table_s;
    logic [2:0] x_r, x_s;
    logic       busy_r, done_r, pass_r;
    logic [2:0] fail_idx_r;
    logic       pass_s;
    logic [2:0] fail_idx_s;

    // Next-state, code/counter sequencing and live truth-table capture.
    always_comb begin
        state_s = state_r;
        code_s  = code_r;
        cnt_s   = cnt_r;
        table_s = table_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SETTLE;
                    code_s  = 3'd0;
                    cnt_s   = 8'd0;
                    table_s = 8'h00;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                cnt_s = cnt_r + 8'd1;
                if (cnt_r == SETTLE_LAST) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = SETTLE;
                end
            end
            SAMPLE: begin
                table_s[code_r] = dut_out;
                if (code_r == 3'd7) begin
                    state_s = DONE;
                end else begin
                    state_s = SETTLE;
                    code_s  = code_r + 3'd1;
                    cnt_s   = 8'd0;
                end
            end
            DONE: begin
                state_s = IDLE;
                code_s  = 3'd0;
            end
            default: begin
                state_s = IDLE;
                code_s  = 3'd0;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Output decode; everything below is registered one cycle behind the state.
    always_comb begin
        if ((state_r == SETTLE) || (state_r == SAMPLE)) begin
            x_s = code_r;
        end else begin
            x_s = 3'd0;
        end
        pass_s     = (table_r == EXPECT);
        fail_idx_s = first_mismatch(table_r ^ EXPECT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            code_r     <= 3'd0;
            cnt_r      <= 8'd0;
            table_r    <= 8'h00;
            x_r        <= 3'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_idx_r <= 3'd0;
        end else begin
            state_r <= state_s;
            code_r  <= code_s;
            cnt_r   <= cnt_s;
            table_r <= table_s;
            x_r     <= x_s;
            busy_r  <= (state_r != IDLE);
            done_r  <= (state_r == DONE);
            if (state_r == DONE) begin
                pass_r     <= pass_s;
                fail_idx_r <= pass_s ? 3'd0 : fail_idx_s;
            end else begin
                pass_r     <= pass_r;
                fail_idx_r <= fail_idx_r;
            end
        end
    end

    assign x1          = x_r[2];
    assign x2          = x_r[1];
    assign x3          = x_r[0];
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign truth_table = table_r;
    assign fail_idx    = fail_idx_r;

endmodule

// File: tb/tb_lab2_truth_sweep.sv
// Scoreboard bench for lab2_truth_sweep: stimulus queues expected sweep results,
// a monitor checks them on each done pulse along with per-code hold times.
module tb_lab2_truth_sweep;

    logic       clk = 1'b0;
    logic       rst_n, start, dut_out;
    logic       x1, x2, x3, busy, done, pass;
    logic [7:0] truth_table;
    logic [2:0] fail_idx;

    int mode = 0;
    int cyc  = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [2:0] idx;
        int         at;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   run = 0;
    int   cur = 0;
    logic [2:0] code;

    lab2_truth_sweep dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
        .x1(x1), .x2(x2), .x3(x3), .busy(busy), .done(done), .pass(pass),
        .truth_table(truth_table), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational block under test, selectable per sweep.
    always_comb begin
        case (mode)
            1:       dut_out = x1 & x2 & x3;
            2:       dut_out = x3;
            3:       dut_out = ~x1;
            4:       dut_out = x1 ^ x2;
            default: dut_out = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop on done, and code-hold tracking while busy.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("truth_table", {24'd0, truth_table}, {24'd0, e.tt});
                check("pass", {31'd0, pass}, {31'd0, e.pass});
                check("fail_idx", {29'd0, fail_idx}, {29'd0, e.idx});
                check("done_cycle", cyc, e.at);
            end
            if (run > 0) begin
                check("hold_last", run, 32'd5);
                check("last_code", cur, 32'd7);
            end
            run = 0;
        end else if (busy) begin
            code = {x1, x2, x3};
            if (run == 0) begin
                check("first_code", {29'd0, code}, 32'd0);
                cur = int'(code);
                run = 1;
            end else if (int'(code) == cur) begin
                run++;
            end else begin
                check("hold", run, 32'd5);
                check("code_step", {29'd0, code}, cur + 1);
                cur = int'(code);
                run = 1;
            end
        end else begin
            run = 0;
        end
    end

    task automatic start_sweep(input int m, input logic [7:0] tt, input logic p, input logic [2:0] idx);
        exp_t x;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        x.tt = tt; x.pass = p; x.idx = idx; x.at = cyc + 42;
        q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int t;
        t = 0;
        while (q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {16'd0, x1, x2, x3, busy, done, pass, truth_table, fail_idx}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("reset_outputs");
        repeat (20) @(negedge clk);
        check_reset_outputs("idle_no_start");

        start_sweep(0, 8'h00, 1'b1, 3'd0);
        wait_empty(300);
        start_sweep(1, 8'h80, 1'b0, 3'd7);
        wait_empty(300);
        start_sweep(2, 8'hAA, 1'b0, 3'd1);
        wait_empty(300);
        repeat (5) @(negedge clk);
        check("hold_table", {24'd0, truth_table}, 32'h0000_00AA);
        check("hold_pass_idx", {28'd0, pass, fail_idx}, 32'd1);

        start_sweep(3, 8'h0F, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        check("table_cleared", {24'd0, truth_table}, 32'd0);
        wait_empty(300);
        start_sweep(4, 8'h3C, 1'b0, 3'd2);
        wait_empty(300);

        // Abort a sweep with reset while code 3 is being driven.
        @(negedge clk);
        mode  = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while ({x1, x2, x3} != 3'd3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_code3", {29'd0, x1, x2, x3}, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_outputs");
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_idle", {31'd0, busy}, 32'd0);
        start_sweep(2, 8'hAA, 1'b0, 3'd1);
        wait_empty(300);

        // start held high: back-to-back sweeps.
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            x.tt = 8'h00; x.pass = 1'b1; x.idx = 3'd0; x.at = k + 41 + 42 * i;
            q.push_back(x);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cyc == k + 41 || cyc == k + 43) check("busy_high_b2b", {31'd0, busy}, 32'd1);
            if (cyc == k + 42) check("busy_gap_b2b", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;
        wait_empty(300);
        repeat (10) @(negedge clk);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
